// File: rtl/img_pool_stream.sv
// Streaming pooling resizer: averages or maxes power-of-two windows of a raster
// pixel stream, keeping one accumulator row instead of a frame buffer.
module img_pool_stream #(
  parameter int IMG_WIDTH_MAX_SIZE  = 1024,
  parameter int IMG_HEIGHT_MAX_SIZE = 1024,
  parameter int IMG_WIDTH_IDX_W     = $clog2(IMG_WIDTH_MAX_SIZE) + 1,
  parameter int IMG_HEIGHT_IDX_W    = $clog2(IMG_HEIGHT_MAX_SIZE) + 1,
  parameter int PXL_PRIM_COLOR_NUM  = 3,
  parameter int PXL_PRIM_COLOR_W    = 8,
  parameter int POOL_LOG2_MAX       = 3,
  parameter int ACC_W               = PXL_PRIM_COLOR_W + 2 * POOL_LOG2_MAX
) (
  input  logic                                           Clk,
  input  logic                                           ResetN,
  input  logic                                           Start,
  input  logic                                           Mode,
  input  logic [IMG_WIDTH_IDX_W-1:0]                     ImgWidth,
  input  logic [IMG_HEIGHT_IDX_W-1:0]                    ImgHeight,
  input  logic [$clog2(POOL_LOG2_MAX+1)-1:0]             PoolWLog2,
  input  logic [$clog2(POOL_LOG2_MAX+1)-1:0]             PoolHLog2,
  input  logic [PXL_PRIM_COLOR_NUM*PXL_PRIM_COLOR_W-1:0] PxlData,
  input  logic                                           PxlVld,
  output logic                                           PxlRdy,
  output logic [PXL_PRIM_COLOR_NUM*PXL_PRIM_COLOR_W-1:0] RszPxlDat,
  output logic [IMG_WIDTH_IDX_W-1:0]                     RszPosX,
  output logic [IMG_HEIGHT_IDX_W-1:0]                    RszPosY,
  output logic                                           RszVld,
  input  logic                                           RszRdy,
  output logic                                           RszLast,
  output logic                                           Busy,
  output logic                                           CfgErr
);
  localparam int XW   = IMG_WIDTH_IDX_W;
  localparam int YW   = IMG_HEIGHT_IDX_W;
  localparam int PL_W = $clog2(POOL_LOG2_MAX + 1);
  localparam int AW   = $clog2(IMG_WIDTH_MAX_SIZE);
  localparam int CW   = PXL_PRIM_COLOR_W;
  localparam int NCH  = PXL_PRIM_COLOR_NUM;
  localparam logic [XW-1:0] X_ONE = 1;
  localparam logic [YW-1:0] Y_ONE = 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  state_t state_reg;

  logic            mode_reg;
  logic [XW-1:0]   w_reg, x_reg;
  logic [YW-1:0]   h_reg, y_reg;
  logic [PL_W-1:0] pwl_reg, phl_reg;

  // Configuration check on the live inputs, evaluated only when Start is seen.
  logic [XW-1:0] w_mask_in;
  logic [YW-1:0] h_mask_in;
  logic          cfg_ok;
  assign w_mask_in = (X_ONE << PoolWLog2) - X_ONE;
  assign h_mask_in = (Y_ONE << PoolHLog2) - Y_ONE;
  assign cfg_ok = (ImgWidth != '0) && (ImgHeight != '0)
               && (ImgWidth <= XW'(IMG_WIDTH_MAX_SIZE))
               && (ImgHeight <= YW'(IMG_HEIGHT_MAX_SIZE))
               && (PoolWLog2 <= PL_W'(POOL_LOG2_MAX))
               && (PoolHLog2 <= PL_W'(POOL_LOG2_MAX))
               && ((ImgWidth & w_mask_in) == '0)
               && ((ImgHeight & h_mask_in) == '0);

  logic [XW-1:0]  kw_mask, ox;
  logic [YW-1:0]  kh_mask;
  logic           win_start, win_end, last_pix, accept;
  logic [PL_W:0]  s_sum;
  logic [AW-1:0]  acc_addr;
  assign kw_mask   = (X_ONE << pwl_reg) - X_ONE;
  assign kh_mask   = (Y_ONE << phl_reg) - Y_ONE;
  assign ox        = x_reg >> pwl_reg;
  assign acc_addr  = ox[AW-1:0];
  assign win_start = ((x_reg & kw_mask) == '0) && ((y_reg & kh_mask) == '0);
  assign win_end   = ((x_reg & kw_mask) == kw_mask) && ((y_reg & kh_mask) == kh_mask);
  assign last_pix  = (x_reg == w_reg - X_ONE) && (y_reg == h_reg - Y_ONE);
  assign s_sum     = {1'b0, pwl_reg} + {1'b0, phl_reg};
  assign PxlRdy    = (state_reg == RUN) && (!RszVld || RszRdy);
  assign accept    = PxlVld && PxlRdy;

  // One accumulator per output column; written only on accepted pixels.
  logic [NCH*ACC_W-1:0] acc_mem [IMG_WIDTH_MAX_SIZE];
  logic [NCH*ACC_W-1:0] acc_rd, acc_wr;
  logic [NCH*CW-1:0]    res_pix;
  assign acc_rd = acc_mem[acc_addr];

  always_ff @(posedge Clk) begin
    if (accept) acc_mem[acc_addr] <= acc_wr;
  end

  genvar gi;
  generate
    for (gi = 0; gi < NCH; gi++) begin : g_ch
      logic [ACC_W-1:0] pix_ext, old_val, new_val;
      logic [ACC_W:0]   rnd, rounded, shifted;
      assign pix_ext = ACC_W'(PxlData[gi*CW +: CW]);
      assign old_val = acc_rd[gi*ACC_W +: ACC_W];
      assign new_val = win_start ? pix_ext :
                       mode_reg  ? ((pix_ext > old_val) ? pix_ext : old_val) :
                                   (old_val + pix_ext);
      // Half-LSB bias gives round-half-up before the divide-by-shift.
      assign rnd     = (s_sum == '0) ? '0 : ((ACC_W+1)'(1) << (s_sum - 1'b1));
      assign rounded = {1'b0, new_val} + rnd;
      assign shifted = rounded >> s_sum;
      assign acc_wr[gi*ACC_W +: ACC_W] = new_val;
      assign res_pix[gi*CW +: CW] = mode_reg ? new_val[CW-1:0] : shifted[CW-1:0];
    end
  endgenerate

  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      state_reg <= IDLE;
      mode_reg  <= 1'b0;
      w_reg     <= '0;
      h_reg     <= '0;
      pwl_reg   <= '0;
      phl_reg   <= '0;
      x_reg     <= '0;
      y_reg     <= '0;
      RszPxlDat <= '0;
      RszPosX   <= '0;
      RszPosY   <= '0;
      RszVld    <= 1'b0;
      RszLast   <= 1'b0;
      Busy      <= 1'b0;
      CfgErr    <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (Start) begin
            if (cfg_ok) begin
              state_reg <= RUN;
              mode_reg  <= Mode;
              w_reg     <= ImgWidth;
              h_reg     <= ImgHeight;
              pwl_reg   <= PoolWLog2;
              phl_reg   <= PoolHLog2;
              x_reg     <= '0;
              y_reg     <= '0;
              Busy      <= 1'b1;
              CfgErr    <= 1'b0;
            end else begin
              CfgErr <= 1'b1;
            end
          end
        end
        RUN: begin
          if (accept) begin
            if (x_reg == w_reg - X_ONE) begin
              x_reg <= '0;
              y_reg <= y_reg + Y_ONE;
            end else begin
              x_reg <= x_reg + X_ONE;
            end
            if (last_pix) state_reg <= DRAIN;
          end
        end
        default: ;
      endcase

      if (RszVld && RszRdy) begin
        RszVld  <= 1'b0;
        RszLast <= 1'b0;
        if (RszLast) begin
          state_reg <= IDLE;
          Busy      <= 1'b0;
        end
      end
      // A completing window overrides the clear above, so back-to-back results need no bubble.
      if (accept && win_end) begin
        RszVld    <= 1'b1;
        RszPxlDat <= res_pix;
        RszPosX   <= ox;
        RszPosY   <= y_reg >> phl_reg;
        RszLast   <= last_pix;
      end
    end
  end
endmodule

// File: tb/tb_img_pool_stream.sv
// Scoreboard bench for img_pool_stream: directed frames push expected results,
// a negedge monitor pops and compares on every output handshake.
module tb_img_pool_stream;
  logic        Clk = 1'b0;
  logic        ResetN, Start, Mode, PxlVld, PxlRdy, RszVld, RszRdy, RszLast, Busy, CfgErr;
  logic [10:0] ImgWidth, ImgHeight, RszPosX, RszPosY;
  logic [1:0]  PoolWLog2, PoolHLog2;
  logic [23:0] PxlData, RszPxlDat;

  always #5 Clk = ~Clk;

  img_pool_stream dut (
    .Clk(Clk), .ResetN(ResetN), .Start(Start), .Mode(Mode),
    .ImgWidth(ImgWidth), .ImgHeight(ImgHeight),
    .PoolWLog2(PoolWLog2), .PoolHLog2(PoolHLog2),
    .PxlData(PxlData), .PxlVld(PxlVld), .PxlRdy(PxlRdy),
    .RszPxlDat(RszPxlDat), .RszPosX(RszPosX), .RszPosY(RszPosY),
    .RszVld(RszVld), .RszRdy(RszRdy), .RszLast(RszLast),
    .Busy(Busy), .CfgErr(CfgErr)
  );

  typedef struct {
    logic [23:0] d;
    int          x;
    int          y;
    logic        last;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic push(input logic [23:0] d, input int x, input int y, input logic last);
    exp_t e;
    e.d = d; e.x = x; e.y = y; e.last = last;
    sb.push_back(e);
  endtask

  always @(negedge Clk) begin
    if (ResetN && RszVld && RszRdy) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_out: got data %0h at (%0d,%0d), expected none", RszPxlDat, RszPosX, RszPosY);
      end else begin
        mon_e = sb.pop_front();
        $display("out data=%06h pos=(%0d,%0d) last=%0b", RszPxlDat, RszPosX, RszPosY, RszLast);
        chk("out_data", 32'(RszPxlDat), 32'(mon_e.d));
        chk("out_posx", 32'(RszPosX), 32'(mon_e.x));
        chk("out_posy", 32'(RszPosY), 32'(mon_e.y));
        chk("out_last", 32'(RszLast), 32'(mon_e.last));
      end
    end
  end

  task automatic start_cfg(input logic m, input int w, input int h, input int pw, input int ph);
    @(posedge Clk); #1;
    Mode = m; ImgWidth = 11'(w); ImgHeight = 11'(h);
    PoolWLog2 = 2'(pw); PoolHLog2 = 2'(ph);
    Start = 1'b1;
    @(posedge Clk); #1;
    Start = 1'b0;
  endtask

  task automatic feed(input logic [23:0] px);
    bit ok;
    ok = 1'b0;
    PxlVld = 1'b1;
    PxlData = px;
    for (int i = 0; i < 100; i++) begin
      @(negedge Clk);
      if (PxlRdy) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_cmp++;
      n_err++;
      $display("FAIL feed_timeout: pixel %06h got no ready, expected ready", px);
    end else begin
      @(posedge Clk); #1;
    end
    PxlVld = 1'b0;
  endtask

  task automatic wait_done(input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge Clk);
      if (sb.size() == 0 && !Busy) begin
        ok = 1'b1;
        break;
      end
    end
    n_cmp++;
    if (!ok) begin
      n_err++;
      $display("FAIL %s: pending=%0d busy=%0b, expected 0/0", name, sb.size(), Busy);
      sb.delete();
    end
  endtask

  task automatic feed_4x4();
    for (int y = 0; y < 4; y++)
      for (int x = 0; x < 4; x++)
        feed(24'(y * 4 + x));
  endtask

  logic [23:0] bp_d;
  logic [10:0] bp_x, bp_y;
  bit          bp_seen;

  initial begin
    ResetN = 1'b0; Start = 1'b0; Mode = 1'b0; PxlVld = 1'b0; PxlData = '0;
    ImgWidth = '0; ImgHeight = '0; PoolWLog2 = '0; PoolHLog2 = '0; RszRdy = 1'b1;
    repeat (3) @(posedge Clk);
    #1;
    chk("rst_vld", 32'(RszVld), 0);
    chk("rst_rdy", 32'(PxlRdy), 0);
    chk("rst_busy", 32'(Busy), 0);
    chk("rst_cfgerr", 32'(CfgErr), 0);
    chk("rst_last", 32'(RszLast), 0);
    ResetN = 1'b1;

    // AVG 2x2 over 4x4 ramp
    push(24'd3, 0, 0, 0); push(24'd5, 1, 0, 0); push(24'd11, 0, 1, 0); push(24'd13, 1, 1, 1);
    start_cfg(1'b0, 4, 4, 1, 1);
    chk("avg_busy", 32'(Busy), 1);
    feed_4x4();
    wait_done("avg_done");

    // MAX 2x2 over same image
    push(24'd5, 0, 0, 0); push(24'd7, 1, 0, 0); push(24'd13, 0, 1, 0); push(24'd15, 1, 1, 1);
    start_cfg(1'b1, 4, 4, 1, 1);
    feed_4x4();
    wait_done("max_done");

    // Backpressure on the first result
    push(24'd3, 0, 0, 0); push(24'd5, 1, 0, 0); push(24'd11, 0, 1, 0); push(24'd13, 1, 1, 1);
    RszRdy = 1'b0;
    start_cfg(1'b0, 4, 4, 1, 1);
    fork
      feed_4x4();
      begin
        bp_seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
          @(negedge Clk);
          if (RszVld) begin
            bp_seen = 1'b1;
            break;
          end
        end
        chk("bp_seen", 32'(bp_seen), 1);
        bp_d = RszPxlDat; bp_x = RszPosX; bp_y = RszPosY;
        chk("bp_first_data", 32'(bp_d), 3);
        repeat (5) begin
          @(negedge Clk);
          chk("bp_vld_hold", 32'(RszVld), 1);
          chk("bp_data_hold", 32'(RszPxlDat), 32'(bp_d));
          chk("bp_pos_hold", 32'({RszPosX, RszPosY}), 32'({bp_x, bp_y}));
          chk("bp_pxlrdy", 32'(PxlRdy), 0);
        end
        @(posedge Clk); #1;
        RszRdy = 1'b1;
      end
    join
    wait_done("bp_done");

    // Invalid config, then a valid rounding frame
    start_cfg(1'b0, 6, 4, 2, 0);
    chk("cfg_err_set", 32'(CfgErr), 1);
    chk("cfg_err_busy", 32'(Busy), 0);
    chk("cfg_err_rdy", 32'(PxlRdy), 0);
    push(24'd2, 0, 0, 1);
    start_cfg(1'b0, 2, 1, 1, 0);
    chk("cfg_err_clr", 32'(CfgErr), 0);
    chk("cfg_ok_busy", 32'(Busy), 1);
    feed(24'd1);
    feed(24'd2);
    wait_done("round_done");

    // 3-channel passthrough with 1-cycle latency
    push(24'h302010, 0, 0, 0); push(24'h605040, 1, 0, 0);
    push(24'h908070, 0, 1, 0); push(24'hC0B0A0, 1, 1, 1);
    start_cfg(1'b0, 2, 2, 0, 0);
    feed(24'h302010);
    chk("pt_lat_vld", 32'(RszVld), 1);
    chk("pt_lat_data", 32'(RszPxlDat), 32'h302010);
    feed(24'h605040);
    chk("pt_lat_data", 32'(RszPxlDat), 32'h605040);
    feed(24'h908070);
    chk("pt_lat_data", 32'(RszPxlDat), 32'h908070);
    feed(24'hC0B0A0);
    chk("pt_lat_data", 32'(RszPxlDat), 32'hC0B0A0);
    wait_done("pt_done");

    // Abort a partial frame with reset, then a fresh frame
    start_cfg(1'b0, 2, 2, 1, 1);
    feed(24'hFFFFFF);
    feed(24'hFFFFFF);
    @(posedge Clk); #1;
    ResetN = 1'b0;
    #1;
    chk("abort_busy", 32'(Busy), 0);
    chk("abort_vld", 32'(RszVld), 0);
    chk("abort_rdy", 32'(PxlRdy), 0);
    @(posedge Clk); #1;
    ResetN = 1'b1;
    push(24'hFF0119, 0, 0, 1);
    start_cfg(1'b0, 2, 2, 1, 1);
    feed(24'hFF010A);
    feed(24'hFF0114);
    feed(24'hFF011E);
    feed(24'hFF0228);
    wait_done("fresh_done");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
